ps2_receiver_fifo: RTL
======================

# ps2_receiver_fifo

PS/2 keyboard receiver that deserialises 11-bit device-to-host frames from the keyboard's `ps2_clk`/`ps2_data` pins and queues valid scan-code bytes in an 8-entry FIFO. It sits directly upstream of `display_scan_codes`, which pops bytes through the `rd` strobe and renders them. Malformed frames are dropped and flagged. Stalled frames are abandoned by a timeout.

## Interface
- `TIMEOUT_CYCLES`, 25000 — idle `clk_sys` cycles in mid-frame before the partial frame is discarded (500 us at 50 MHz).
- `FIFO_AW`, 3 — FIFO address width; depth = 2^FIFO_AW = 8.

Ports:
- `clk_sys`  in  1  — system clock, all logic on its rising edge.
- `clr`  in  1  — synchronous, active-high reset.
- `ps2_clk`  in  1  — raw keyboard clock, asynchronous to `clk_sys`.
- `ps2_data`  in  1  — raw keyboard data, asynchronous.
- `rd`  in  1  — pop strobe, one byte consumed per cycle high while `ready`=1.
- `data`  out  8  — FIFO head (show-ahead); 8'h00 when empty.
- `ready`  out  1  — FIFO non-empty.
- `overflow`  out  1  — sticky; set when a valid byte is dropped because the FIFO is full; cleared only by `clr`.
- `frame_err`  out  1  — one-cycle pulse on a discarded frame (bad start, stop or parity, or timeout).

## Operation
- Synchroniser: 3 flops on `ps2_clk` (`s[2:0]`), 3 flops on `ps2_data` (aligned). Falling edge `fe` = `s[2:1]==2'b10`. Data is sampled from the matching stage.
- FSM states:
  - IDLE: on `fe` with sampled data 0 (start bit), go to RECV with `bitcnt`=1. On `fe` with data 1, stay in IDLE (no error).
  - RECV: each `fe` shifts the sample into the frame register and increments `bitcnt`. Bits 1–8 are data, LSB first. Bit 9 is odd parity. Bit 10 is stop.
  - On the `fe` that captures bit 10, return to IDLE. Push if stop==1 and XOR of data[7:0] and parity is 1. Otherwise pulse `frame_err`.
- Timeout counter:
  - Clears on every `fe` and runs only in RECV.
  - Reaching `TIMEOUT_CYCLES-1` returns the FSM to IDLE, pulses `frame_err`, pushes nothing.
- FIFO:
  - Structure: `wp`, `rp` (FIFO_AW bits, wrap modulo depth) and `count` (FIFO_AW+1 bits, 0..8).
  - Push when count<8 or a pop happens in the same cycle. Otherwise drop the byte and set `overflow`.
  - Pop when `rd` && count>0. `rd` on an empty FIFO is ignored and harmless.
  - Simultaneous push and pop: both take effect and count is unchanged, including at count=8 and count=0 (at count=0 only the push happens).
- `ready` = (count!=0). `data` = mem[rp] gated to 0 when empty.
- `clr` mid-frame: discard the partial frame, empty the FIFO, no `frame_err`. Reception restarts only on the next start bit after `clr` deasserts.

## Timing
- Reset values (cycle after `clr` sampled high):
  - FSM = IDLE; bitcnt = 0; timeout counter = 0.
  - wp = rp = count = 0.
  - `ready`=0, `data`=8'h00, `overflow`=0, `frame_err`=0.
  - Synchroniser flops = 1 (bus idle high).
- Edge-detect latency: a `ps2_clk` fall sampled at rising edge N produces `fe` during cycle N+2.
- Push occurs at the end of the `fe` cycle of the stop bit. `ready` and `data` are valid the following cycle. This is 3 cycles after the stop-bit fall is first sampled.
- Pop: `rd` high in cycle K advances `rp`. The new head appears on `data` in cycle K+1, and `ready` drops in K+1 if the FIFO became empty.
- `frame_err` is high for exactly one cycle: the stop-bit `fe` cycle+1, or the timeout cycle+1.
- `ps2_clk` high/low phases ≥ 3 `clk_sys` periods are required. Shorter glitches are not guaranteed to be rejected.

## Test plan
- Send one valid frame for 0x1C (parity 0) → `ready`=1, `data`=8'h1C, `frame_err`=0. Pulse `rd` → `ready`=0, `data`=8'h00.
- Send 0xF0 then 0x1C, with no reads → head 8'hF0. After one `rd` → head 8'h1C. After a second `rd` → `ready`=0.
- Send 0x1C with parity bit 1 (wrong) → `frame_err` one-cycle pulse, `ready` stays 0. A following valid 0x32 → `data`=8'h32.
- Send 9 valid frames 0x01..0x09 without reads → count 8, `overflow`=1, reads return 0x01..0x08 then `ready`=0. `overflow` remains 1 until `clr`.
- Send start bit plus 4 data bits, then hold `ps2_clk` high for `TIMEOUT_CYCLES`+10 cycles → `frame_err` pulse, FSM IDLE. A following valid 0x29 → only 0x29 queued.
- Assert `clr` mid-frame with 2 bytes queued → `ready`=0, `overflow`=0, no `frame_err`. A following valid 0x5A is received correctly. At count=8 with `rd` and a push in the same cycle → count stays 8, `overflow` stays 0.

Source files
------------

// File: rtl/ps2_receiver_fifo.sv
// PS/2 device-to-host frame receiver feeding an 8-entry show-ahead byte FIFO.
// Bad or stalled frames are dropped with a one-cycle frame_err pulse.
module ps2_receiver_fifo #(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int FIFO_AW        = 3
) (
    input  logic       clk_sys,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_RECV
    } state_t;

    logic [2:0]         clk_sync_reg;
    logic [2:0]         data_sync_reg;
    state_t             state_reg;
    logic [3:0]         bitcnt_reg;
    logic [8:0]         shift_reg;
    logic [TO_W-1:0]    to_cnt_reg;
    logic               frame_err_reg;

    logic [7:0]         mem_reg [DEPTH];
    logic [FIFO_AW-1:0] wp_reg;
    logic [FIFO_AW-1:0] rp_reg;
    logic [FIFO_AW:0]   count_reg;
    logic               overflow_reg;

    logic fe;
    logic bit_in;
    logic frame_done;
    logic frame_good;
    logic push_req;
    logic fifo_full;
    logic do_pop;
    logic do_push;

    // Bus idles high, so the synchronisers reset to 1 to avoid a false fall.
    always_ff @(posedge clk_sys) begin
        if (clr) begin
            clk_sync_reg  <= 3'b111;
            data_sync_reg <= 3'b111;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[1:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[1:0], ps2_data};
        end
    end

    assign fe     = (clk_sync_reg[2:1] == 2'b10);
    assign bit_in = data_sync_reg[2];

    // shift_reg holds {parity, data[7:0]} once bit 9 has been captured.
    assign frame_done = (state_reg == ST_RECV) && fe && (bitcnt_reg == 4'd10);
    assign frame_good = bit_in && (^shift_reg);
    assign push_req   = frame_done && frame_good;

    always_ff @(posedge clk_sys) begin
        if (clr) begin
            state_reg     <= ST_IDLE;
            bitcnt_reg    <= 4'd0;
            shift_reg     <= 9'd0;
            to_cnt_reg    <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    to_cnt_reg <= '0;
                    if (fe && !bit_in) begin
                        state_reg  <= ST_RECV;
                        bitcnt_reg <= 4'd1;
                    end
                end
                ST_RECV: begin
                    if (fe) begin
                        to_cnt_reg <= '0;
                        if (bitcnt_reg == 4'd10) begin
                            state_reg  <= ST_IDLE;
                            bitcnt_reg <= 4'd0;
                            if (!frame_good) begin
                                frame_err_reg <= 1'b1;
                            end
                        end else begin
                            shift_reg  <= {bit_in, shift_reg[8:1]};
                            bitcnt_reg <= bitcnt_reg + 4'd1;
                        end
                    end else if (to_cnt_reg == TO_LAST) begin
                        state_reg     <= ST_IDLE;
                        bitcnt_reg    <= 4'd0;
                        to_cnt_reg    <= '0;
                        frame_err_reg <= 1'b1;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign fifo_full = count_reg[FIFO_AW];
    assign do_pop    = rd && (count_reg != '0);
    assign do_push   = push_req && (!fifo_full || do_pop);

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem_reg[wp_reg] <= shift_reg[7:0];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (clr) begin
            wp_reg       <= '0;
            rp_reg       <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_push) begin
                wp_reg <= wp_reg + 1'b1;
            end
            if (do_pop) begin
                rp_reg <= rp_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (push_req && !do_push) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign ready     = (count_reg != '0);
    assign data      = ready ? mem_reg[rp_reg] : 8'h00;
    assign overflow  = overflow_reg;
    assign frame_err = frame_err_reg;

endmodule
